// File: rtl/bg_scanline_fetcher_if.sv
// -----------------------------------------------------------------------------
// bg_scanline_fetcher_if
// Bus bundle for the background scanline fetcher.
//   VRAM read port : vram_req/vram_addr (fetcher -> VRAM),
//                    vram_ack/vram_rdata (VRAM -> fetcher)
//   Pixel stream   : pix_valid/pix_color/pix_x (fetcher -> palette stage),
//                    pix_ready (palette stage -> fetcher)
// Modports: master = fetcher side, slave = VRAM / downstream side.
// -----------------------------------------------------------------------------
interface bg_scanline_fetcher_if #(
  parameter int VRAM_AW = 13
);
  logic               vram_req;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_ack;
  logic [7:0]         vram_rdata;
  logic               pix_valid;
  logic               pix_ready;
  logic [1:0]         pix_color;
  logic [7:0]         pix_x;

  modport master (
    output vram_req, vram_addr, pix_valid, pix_color, pix_x,
    input  vram_ack, vram_rdata, pix_ready
  );

  modport slave (
    input  vram_req, vram_addr, pix_valid, pix_color, pix_x,
    output vram_ack, vram_rdata, pix_ready
  );
endinterface

// File: rtl/bg_scanline_fetcher.sv
// -----------------------------------------------------------------------------
// bg_scanline_fetcher
// Reads the background map and tile rows from VRAM and streams one scanline of
// LINE_PIXELS two-bit colour indices, applying ScrollX/ScrollY. Fetch and emit
// are sequential per tile: map byte, low plane byte, high plane byte, 8 pixels.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : one-cycle pulse, begin line ly (ignored while busy)
//   ly, scx, scy        : line number and scroll, sampled on start
//   map_select          : background map base (0: MAP0_BASE, 1: MAP1_BASE)
//   tile_data_select    : 1 = unsigned tiles at 0x0000, 0 = signed around 0x1000
//   bus (master)        : VRAM read port and pixel stream
//   busy                : line in progress
//   line_done           : one-cycle pulse after the last pixel is accepted
// -----------------------------------------------------------------------------
module bg_scanline_fetcher #(
  parameter int                 LINE_PIXELS = 160,
  parameter int                 VRAM_AW     = 13,
  parameter logic [VRAM_AW-1:0] MAP0_BASE   = 13'h1800,
  parameter logic [VRAM_AW-1:0] MAP1_BASE   = 13'h1C00
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [7:0]                   ly,
  input  logic [7:0]                   scx,
  input  logic [7:0]                   scy,
  input  logic                         map_select,
  input  logic                         tile_data_select,
  bg_scanline_fetcher_if.master        bus,
  output logic                         busy,
  output logic                         line_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP_RD, S_LO_RD, S_HI_RD, S_EMIT, S_DONE
  } state_e;

  localparam logic [7:0]         LAST_X      = 8'(LINE_PIXELS - 1);
  localparam logic [VRAM_AW-1:0] SIGNED_BASE = VRAM_AW'(13'h1000);

  state_e      state_q, state_d;
  logic [7:0]  y_q, y_d;            // background row: ly + scy (mod 256)
  logic [4:0]  col_q, col_d;        // map column of the tile being fetched
  logic [2:0]  fine_q, fine_d;      // pixels dropped from the first tile
  logic        map_sel_q, map_sel_d;
  logic        tds_q, tds_d;
  logic        first_q, first_d;    // currently emitting tile 0 of the line
  logic [7:0]  tile_q, tile_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [2:0]  bit_q, bit_d;        // pixel index k within the buffered tile row
  logic [7:0]  pix_x_q, pix_x_d;

  logic               discard;
  logic               emit_valid;
  logic               xfer;
  logic [VRAM_AW-1:0] map_addr;
  logic [VRAM_AW-1:0] row_addr;
  logic [2:0]         bit_sel;

  // Leading pixels of tile 0 are skipped without a handshake to apply fine scroll.
  assign discard    = (state_q == S_EMIT) && first_q && (bit_q < fine_q);
  assign emit_valid = (state_q == S_EMIT) && !discard;
  assign xfer       = emit_valid && bus.pix_ready;
  assign bit_sel    = 3'd7 - bit_q;

  // {y[7:3], col} is y[7:3]*32 + col.
  assign map_addr = (map_sel_q ? MAP1_BASE : MAP0_BASE) + VRAM_AW'({y_q[7:3], col_q});

  // Signed mode sign-extends the tile index, so 0x80..0xFF land below 0x1000.
  assign row_addr = (tds_q ? '0 : SIGNED_BASE)
                  + {{(VRAM_AW-12){tile_q[7] & ~tds_q}}, tile_q, 4'b0000}
                  + VRAM_AW'({y_q[2:0], 1'b0});

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the tile buffers and index are plain flops, so they are cleared
      // with everything else; no X can reach pix_color after reset.
      state_q   <= S_IDLE;
      y_q       <= '0;
      col_q     <= '0;
      fine_q    <= '0;
      map_sel_q <= 1'b0;
      tds_q     <= 1'b0;
      first_q   <= 1'b0;
      tile_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      bit_q     <= '0;
      pix_x_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q   <= state_d;
      y_q       <= y_d;
      col_q     <= col_d;
      fine_q    <= fine_d;
      map_sel_q <= map_sel_d;
      tds_q     <= tds_d;
      first_q   <= first_d;
      tile_q    <= tile_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      bit_q     <= bit_d;
      pix_x_q   <= pix_x_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: hold-value defaults first so no path leaves a latch behind.
    state_d   = state_q;
    y_d       = y_q;
    col_d     = col_q;
    fine_d    = fine_q;
    map_sel_d = map_sel_q;
    tds_d     = tds_q;
    first_d   = first_q;
    tile_d    = tile_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    bit_d     = bit_q;
    pix_x_d   = pix_x_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_MAP_RD;
          y_d       = ly + scy;
          col_d     = scx[7:3];
          fine_d    = scx[2:0];
          map_sel_d = map_select;
          tds_d     = tile_data_select;
          first_d   = 1'b1;
          bit_d     = '0;
          pix_x_d   = '0;
        end
      end
      S_MAP_RD: begin
        if (bus.vram_ack) begin
          tile_d  = bus.vram_rdata;
          state_d = S_LO_RD;
        end
      end
      S_LO_RD: begin
        if (bus.vram_ack) begin
          lo_d    = bus.vram_rdata;
          state_d = S_HI_RD;
        end
      end
      S_HI_RD: begin
        if (bus.vram_ack) begin
          hi_d    = bus.vram_rdata;
          bit_d   = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (xfer && (pix_x_q == LAST_X)) begin
          // The last tile may be only partly used when fine scroll is non-zero.
          state_d = S_DONE;
          pix_x_d = '0;
        end else if (xfer || discard) begin
          if (xfer) pix_x_d = pix_x_q + 8'd1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_MAP_RD;
            col_d   = col_q + 5'd1;   // wraps at 32 columns
            first_d = 1'b0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    bus.vram_req  = 1'b0;
    bus.vram_addr = '0;
    busy          = 1'b0;
    line_done     = 1'b0;
    unique case (state_q)
      S_MAP_RD: begin
        busy          = 1'b1;
        bus.vram_req  = 1'b1;
        bus.vram_addr = map_addr;
      end
      S_LO_RD: begin
        busy          = 1'b1;
        bus.vram_req  = 1'b1;
        bus.vram_addr = row_addr;
      end
      S_HI_RD: begin
        busy          = 1'b1;
        bus.vram_req  = 1'b1;
        bus.vram_addr = row_addr + VRAM_AW'(1);
      end
      S_EMIT:  busy      = 1'b1;
      S_DONE:  line_done = 1'b1;
      default: ;
    endcase
    bus.pix_valid = emit_valid;
    bus.pix_color = emit_valid ? {hi_q[bit_sel], lo_q[bit_sel]} : 2'b00;
    bus.pix_x     = pix_x_q;
  end

endmodule

// File: doc/bg_scanline_fetcher.md
Name: bg_scanline_fetcher

Overview:
Background scanline fetcher for the whizgraphics pixel pipeline. It reads the background tile map and tile data from VRAM, which the CPU or bench writes, and emits one scanline of 160 two-bit colour indices, applying ScrollX/ScrollY.
It sits between the VRAM read port and the palette/LCD stage. It is the read side of the tile and background-map structures.

Parameters:
LINE_PIXELS, 160, pixels emitted per line
VRAM_AW, 13, VRAM byte-address width (8 KB)
MAP0_BASE, 13'h1800, background map base when map_select=0
MAP1_BASE, 13'h1C00, background map base when map_select=1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin fetching line ly
ly  in  8  current LCD line
scx  in  8  ScrollX
scy  in  8  ScrollY
map_select  in  1  background map base select
tile_data_select  in  1  1 = unsigned tiles at 0x0000; 0 = signed tiles around 0x1000
vram_req  out  1  VRAM read request
vram_addr  out  VRAM_AW  VRAM read address
vram_ack  in  1  read complete; vram_rdata valid this cycle
vram_rdata  in  8  VRAM read data
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
pix_color  out  2  colour index {hi bit, lo bit}
pix_x  out  8  screen x of pixel, 0..159
busy  out  1  line in progress
line_done  out  1  one-cycle pulse after last pixel is accepted

Behaviour:
- Reset (async, reset_n=0): FSM to IDLE. All outputs are 0: vram_req, vram_addr, pix_valid, pix_color, pix_x, busy, line_done. Internal counters and buffers are cleared. Reset asserted mid-line aborts the line immediately; no line_done is generated.
- start, ly, scx, scy, map_select and tile_data_select are sampled on the start cycle and held for the whole line. start while busy=1 is ignored.
- Derived values:
  - y = (ly+scy) mod 256
  - col0 = scx[7:3]
  - fine = scx[2:0]
  - tile n uses map column (col0+n) mod 32, so it wraps at 32
- Map address = base + y[7:3]*32 + column.
- Tile row address:
  - tile_data_select=1: t*16 + y[2:0]*2, with t unsigned.
  - tile_data_select=0: 0x1000 + signed(t)*16 + y[2:0]*2. t=0x80 maps to 0x0800; t=0x7F maps to 0x17F0.
  - The high byte is read at row address + 1.
- FSM states:
  - IDLE: start -> MAP_RD, busy=1.
  - MAP_RD: request map byte; on vram_ack latch tile index -> LO_RD.
  - LO_RD: request low byte; on ack -> HI_RD.
  - HI_RD: request high byte; on ack load the 8-pixel shift buffer -> EMIT.
  - EMIT: pixel k of the buffer has colour {hi[7-k], lo[7-k]}. For tile 0 only, the first `fine` pixels are discarded internally without asserting pix_valid. When the buffer is empty -> MAP_RD for the next tile. After pixel LINE_PIXELS-1 is accepted -> DONE.
  - DONE: line_done=1 for one cycle, busy=0 -> IDLE.
- Tiles fetched per line: 20 when fine=0, 21 otherwise.
- VRAM handshake:
  - vram_req rises in the cycle the read state is entered.
  - vram_addr is stable while vram_req=1.
  - vram_req drops in the cycle after vram_ack.
  - vram_ack with vram_req=0 is ignored.
  - Wait states are unlimited.
- Pixel handshake:
  - A transfer occurs when pix_valid && pix_ready on a rising edge.
  - pix_color and pix_x are stable while pix_valid=1 && !pix_ready.
  - pix_x increments by 1 per transfer, starting at 0.
  - Once asserted, pix_valid does not deassert before a transfer.
- Throughput is not pipelined: fetch and emit do not overlap. Each tile costs at least 3 ack cycles plus 8 emit cycles.

Test Plan:
- Reset then start, ly=0, scx=scy=0, map[0x1800]=1, tile 1 row0 lo=0xF0 hi=0xF0, pix_ready=1, vram_ack one cycle after req -> first 8 pixels 3,3,3,3,0,0,0,0 with pix_x 0..7; addresses 0x1800, 0x0010, 0x0011; exactly 160 transfers, then one line_done pulse.
- scx=3, map tile 1 at col 0, tile 2 at col 1 -> pix_x=0 carries tile-1 pixel 3; tile-2 pixel 0 appears at pix_x=5; 21 map reads total.
- scx=0xF8 -> first map read at column 31 (0x181F), second at column 0 (0x1800).
- ly=0x90, scy=0x80, tile_data_select=0, map entry 0x80 -> y=0x10, map address 0x1800+2*32=0x1840; tile row address 0x0800.
- Random pix_ready low and vram_ack delays of 0–5 cycles -> pix_color/pix_x and vram_addr stable while stalled; pixel sequence identical to the no-stall run.
- reset_n low after 50 pixels, then high, then start -> outputs 0 during reset, no line_done; new line begins at pix_x=0; start pulsed mid-line is ignored.
